mux_rr: RTL
===========

# mux_rr

Parametrised, registered N-channel multiplexer with valid/ready handshaking on every input and on the output. It has two selection modes: an externally driven select and round-robin arbitration among the channels that are presenting data. It sits where several producers share one datapath consumer, for example instruction-fetch, load/store and debug requests sharing the memory port. It replaces ad-hoc 2:1 combinational muxes on those paths.

## Interface
- WIDTH, 8, data width per channel (≥1)
- N, 4, channel count (2..16)
- SW, $clog2(N), select/source index width (derived; do not override)

- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock; asynchronous, active-low
- mode  input  1  0 = fixed select via sel; 1 = round-robin
- sel  input  SW  channel index used when mode=0
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready (combinational)
- out_data  output  WIDTH  registered data
- out_src  output  SW  index of the channel that supplied out_data
- out_valid  output  1  registered valid
- out_ready  input  1  downstream ready

## Operation
- There is a single output register stage (data, src, valid) and a round-robin pointer `ptr` (SW bits), where `ptr` is the highest-priority channel.
- can_load = !out_valid || out_ready.
- **Grant, mode=0:**
  - grant is one-hot on `sel` if sel < N and in_valid[sel].
  - Otherwise there is no grant.
  - sel ≥ N (N not a power of two) never grants.
- **Grant, mode=1:** grant goes to the first channel with in_valid set, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrapping modulo N).
- in_ready[i] = grant[i] && can_load. At most one bit is set.
- in_ready must not depend on in_valid of other channels in mode=0.
- **Transfer in** on channel g when in_valid[g] && in_ready[g]:
  - out_data ← channel g data
  - out_src ← g
  - out_valid ← 1
  - In mode=1 only, ptr ← (g+1) mod N.
- **Transfer out** when out_valid && out_ready. If there is no simultaneous transfer in, out_valid ← 0. out_data and out_src hold their values.
- **Simultaneous out and in:** the register reloads with the new beat and out_valid stays 1. This gives full throughput of one beat per cycle.
- While out_valid && !out_ready:
  - out_data and out_src are stable.
  - All in_ready are 0.
  - ptr is unchanged.
- Mode-0 transfers do not move ptr.
- Changes to mode or sel affect only the next grant. A held beat is unaffected.
- No beat is duplicated or dropped.
- Inputs are expected to follow valid/ready rules: data is held stable while valid && !ready. The block does not check this.

## Timing
- **Reset (rst_n low, asynchronous):**
  - out_valid=0, out_data=0, out_src=0, ptr=0.
  - in_ready follows the combinational rule (can_load=1), so a valid input may see ready during reset, but no capture occurs.
- **Release:** the first capture happens on the first rising edge with rst_n high.
- **Latency:** one cycle from input handshake to out_valid.
- **Throughput:** one beat per cycle when out_ready is held high.
- **Reset mid-operation:** any held beat is discarded and ptr returns to 0.
- **Combinational paths:**
  - in_ready depends on out_ready, out_valid, mode, sel, in_valid and ptr.
  - out_* are register outputs only.

## Test plan
- **Reset:** assert rst_n=0 mid-stream with out_valid=1 → out_valid=0, out_data=0 and out_src=0 immediately (before the next edge). After release, ptr=0, so with all four valid, channel 0 wins first.
- **Fixed select, N=4, WIDTH=8, mode=0, sel=2:**
  - Channel 2 = 0xA5 valid, other channels also valid, out_ready=1 → next cycle out_data=0xA5, out_src=2.
  - in_ready = 4'b0100.
- **Round-robin fairness, mode=1:** all 4 channels continuously valid, out_ready=1 → out_src sequence 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
- **Round-robin skip and wrap:** only channels 1 and 3 valid, ptr=2 → channel 3 granted, ptr becomes 0. Next grant is channel 1, ptr becomes 2.
- **Backpressure:** out_ready=0 for 3 cycles with out_valid=1 (data 0x3C) → out_data stays 0x3C, in_ready=0, ptr unchanged. Then out_ready=1 with channel 0 valid (0x11) → same-cycle reload, out_valid stays 1, out_data=0x11.
- **Out-of-range select, N=3:** mode=0, sel=3, all valid → in_ready=0 and out_valid stays 0. Switching to mode=1 resumes grants starting at ptr.

Source files
------------

// File: rtl/mux_rr.sv
// Registered N-channel mux with valid/ready on every port. A channel is chosen
// either by an external select (mode=0) or by round-robin over the valid channels (mode=1).
module mux_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SW-1:0]      sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  // Handshake: a beat moves on any port in a cycle where both its valid and
  // its ready are high at the rising edge. The upstream side holds data
  // stable while valid && !ready. in_ready is combinational. out_* are registered.

  logic [WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]    src_q, src_d;
  logic [SW-1:0]    ptr_q, ptr_d;
  logic             valid_q, valid_d;

  logic             can_load;
  logic             load;
  logic [N-1:0]     grant;
  logic [SW-1:0]    gidx;
  logic [SW-1:0]    ptr_nxt;
  logic [SW:0]      rr_idx;
  logic             found;
  logic [WIDTH-1:0] sel_data;

  assign can_load = !valid_q || out_ready;

  // Fixed mode compares sel against every real channel, so an out-of-range sel never grants.
  always_comb begin
    grant  = '0;
    gidx   = '0;
    found  = 1'b0;
    rr_idx = '0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SW'(i) && in_valid[i]) begin
          grant[i] = 1'b1;
          gidx     = SW'(i);
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        rr_idx = {1'b0, ptr_q} + (SW+1)'(k);
        if (rr_idx >= (SW+1)'(N)) rr_idx = rr_idx - (SW+1)'(N);
        if (!found && in_valid[rr_idx[SW-1:0]]) begin
          found               = 1'b1;
          grant               = '0;
          grant[rr_idx[SW-1:0]] = 1'b1;
          gidx                = rr_idx[SW-1:0];
        end
      end
    end
  end

  assign in_ready = grant & {N{can_load}};
  assign load     = |in_ready;
  assign ptr_nxt  = (gidx == SW'(N-1)) ? '0 : gidx + SW'(1);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gidx == SW'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // A load while the held beat leaves is a same-cycle reload; valid stays high.
  always_comb begin
    data_d  = data_q;
    src_d   = src_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load) begin
      data_d  = sel_data;
      src_d   = gidx;
      valid_d = 1'b1;
      if (mode) ptr_d = ptr_nxt;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_valid = valid_q;

endmodule
